// File: rtl/sub_int32_serial_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
// The master side issues operands with start; the slave side returns
// ready, a one-cycle valid pulse and the held Diff/Borrow result.
interface sub_int32_serial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;

    modport master (
        output start, A, B,
        input  ready, valid, Diff, Borrow
    );

    modport slave (
        input  start, A, B,
        output ready, valid, Diff, Borrow
    );
endinterface

// File: rtl/sub_int32_serial.sv
// Digit-serial subtractor: Diff = A - B computed as A + ~B + 1,
// DIGIT bits per cycle, least significant slice first.
// Sequence: IDLE (ready) -> RUN (N slice cycles) -> DONE (result publish).
module sub_int32_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic clk,
    input  logic rst,
    sub_int32_serial_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    // N=1 still needs a one-bit counter so the compare below stays legal.
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] opa_reg;
    logic [WIDTH-1:0] opb_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic             borrow_reg;
    logic             valid_reg;

    logic [DIGIT:0]   slice_sum;
    logic [WIDTH-1:0] res_shift;
    logic             last_slice;

    // One slice of the ripple: low digit of each operand plus incoming carry.
    assign slice_sum  = {1'b0, opa_reg[DIGIT-1:0]} + {1'b0, opb_reg[DIGIT-1:0]}
                      + {{DIGIT{1'b0}}, carry_reg};
    // New sum digit enters at the top; after N slices the LSB digit sits at the bottom.
    assign res_shift  = (res_reg >> DIGIT)
                      | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign last_slice = (cnt_reg == CNT_W'(N - 1));

    assign bus.ready  = (state_reg == IDLE);
    assign bus.valid  = valid_reg;
    assign bus.Diff   = diff_reg;
    assign bus.Borrow = borrow_reg;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start outside IDLE is simply not looked at.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_slice) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and per-slice shift/accumulate datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_reg   <= '0;
            opb_reg   <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (state_reg == IDLE && bus.start) begin
            opa_reg   <= bus.A;
            opb_reg   <= ~bus.B;
            cnt_reg   <= '0;
            carry_reg <= 1'b1;
        end else if (state_reg == RUN) begin
            opa_reg   <= opa_reg >> DIGIT;
            opb_reg   <= opb_reg >> DIGIT;
            res_reg   <= res_shift;
            cnt_reg   <= cnt_reg + 1'b1;
            carry_reg <= slice_sum[DIGIT];
        end
    end

    // Result publish: outputs only move on the DONE cycle, so they hold during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= (state_reg == DONE);
            if (state_reg == DONE) begin
                diff_reg   <= res_reg;
                borrow_reg <= ~carry_reg;
            end
        end
    end
endmodule

// File: tb/tb_sub_int32_serial.sv
// Bench for sub_int32_serial: directed scenarios on the DIGIT=4 instance and
// back-to-back random sweeps on DIGIT = 1, 4, 8 and 32 instances.
module tb_sub_int32_serial;
    localparam int WIDTH = 32;
    localparam int NINST = 4;
    localparam int K4    = 1;   // index of the DIGIT=4 instance

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_v  [NINST];
    logic [31:0] a_v      [NINST];
    logic [31:0] b_v      [NINST];
    logic        ready_v  [NINST];
    logic        valid_v  [NINST];
    logic [31:0] diff_v   [NINST];
    logic        borrow_v [NINST];

    logic [31:0] exp_diff_q[$];
    logic        exp_borrow_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
        localparam int DIG = (gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 8 : 32;
        sub_int32_serial_if #(.WIDTH(WIDTH)) bus ();
        assign bus.start    = start_v[gi];
        assign bus.A        = a_v[gi];
        assign bus.B        = b_v[gi];
        assign ready_v[gi]  = bus.ready;
        assign valid_v[gi]  = bus.valid;
        assign diff_v[gi]   = bus.Diff;
        assign borrow_v[gi] = bus.Borrow;
        sub_int32_serial #(.WIDTH(WIDTH), .DIGIT(DIG)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int digit_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : (k == 2) ? 8 : 32;
    endfunction

    // Drive one request for a single cycle and record its expected result.
    task automatic launch(input int k, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        a_v[k] = a; b_v[k] = b; start_v[k] = 1'b1;
        exp_diff_q.push_back(a - b);
        exp_borrow_q.push_back(a < b);
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        a_v[k] = $urandom(); b_v[k] = $urandom();
    endtask

    task automatic wait_valid(input int k, input int budget, output int cycles, output bit got);
        cycles = 0; got = 1'b0;
        while (!got && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
            if (valid_v[k] === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < NINST; k++) begin
            start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NINST; k++) begin
            total_cnt++;
            if (ready_v[k] !== 1'b1 || valid_v[k] !== 1'b0 || diff_v[k] !== 32'h0 || borrow_v[k] !== 1'b0)
                $display("FAIL reset[%0d]: got ready=%b valid=%b diff=%h borrow=%b expected 1 0 00000000 0",
                         k, ready_v[k], valid_v[k], diff_v[k], borrow_v[k]);
            else pass_cnt++;
        end
        rst = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_basic();
        logic [31:0] ta [5] = '{32'd5, 32'd3, 32'd0, 32'h8000_0000, 32'hDEAD_BEEF};
        logic [31:0] tb [5] = '{32'd3, 32'd5, 32'd1, 32'd1,         32'hDEAD_BEEF};
        logic [31:0] ed [5] = '{32'h2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0};
        logic        eb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int cyc; bit got;
        logic [31:0] qd; logic qb;
        for (int i = 0; i < 5; i++) begin
            launch(K4, ta[i], tb[i]);
            total_cnt++;
            if (ready_v[K4] !== 1'b0) $display("FAIL basic_busy[%0d]: got ready=%b expected 0", i, ready_v[K4]);
            else pass_cnt++;
            wait_valid(K4, 40, cyc, got);
            qd = exp_diff_q.pop_front(); qb = exp_borrow_q.pop_front();
            total_cnt++;
            if (!got) begin
                $display("FAIL basic_timeout[%0d]: got no valid expected valid within 40 cycles", i);
                continue;
            end else pass_cnt++;
            $display("basic: A=%h B=%h Diff=%h Borrow=%b latency=%0d", ta[i], tb[i], diff_v[K4], borrow_v[K4], cyc);
            total_cnt++;
            if (cyc !== 9) $display("FAIL basic_latency[%0d]: got %0d expected 9", i, cyc);
            else pass_cnt++;
            total_cnt++;
            if (diff_v[K4] !== ed[i] || diff_v[K4] !== qd)
                $display("FAIL basic_diff[%0d]: got %h expected %h", i, diff_v[K4], ed[i]);
            else pass_cnt++;
            total_cnt++;
            if (borrow_v[K4] !== eb[i] || borrow_v[K4] !== qb)
                $display("FAIL basic_borrow[%0d]: got %b expected %b", i, borrow_v[K4], eb[i]);
            else pass_cnt++;
            total_cnt++;
            if (ready_v[K4] !== 1'b1) $display("FAIL basic_ready_on_valid[%0d]: got %b expected 1", i, ready_v[K4]);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (valid_v[K4] !== 1'b0) $display("FAIL basic_pulse[%0d]: got valid=%b expected 0", i, valid_v[K4]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignored_start();
        int cyc; bit got; int extra;
        logic [31:0] qd; logic qb;
        launch(K4, 32'h10, 32'h100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a_v[K4] = 32'd9; b_v[K4] = 32'd1; start_v[K4] = 1'b1;
        total_cnt++;
        if (ready_v[K4] !== 1'b0) $display("FAIL ignored_ready: got %b expected 0", ready_v[K4]);
        else pass_cnt++;
        @(posedge clk); #1;
        start_v[K4] = 1'b0;
        wait_valid(K4, 40, cyc, got);
        qd = exp_diff_q.pop_front(); qb = exp_borrow_q.pop_front();
        total_cnt++;
        if (!got || diff_v[K4] !== qd || borrow_v[K4] !== qb)
            $display("FAIL ignored_result: got valid=%b diff=%h borrow=%b expected 1 %h %b",
                     got, diff_v[K4], borrow_v[K4], qd, qb);
        else pass_cnt++;
        $display("ignored_start: Diff=%h Borrow=%b", diff_v[K4], borrow_v[K4]);
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (valid_v[K4] === 1'b1) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL ignored_extra_valid: got %0d expected 0", extra);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int cyc; bit got; int extra;
        logic [31:0] qd; logic qb;
        launch(K4, 32'h1234, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (ready_v[K4] !== 1'b1 || valid_v[K4] !== 1'b0 || diff_v[K4] !== 32'h0 || borrow_v[K4] !== 1'b0)
            $display("FAIL async_reset: got ready=%b valid=%b diff=%h borrow=%b expected 1 0 00000000 0",
                     ready_v[K4], valid_v[K4], diff_v[K4], borrow_v[K4]);
        else pass_cnt++;
        exp_diff_q.delete(); exp_borrow_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (valid_v[K4] === 1'b1) extra++;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL async_aborted_valid: got %0d expected 0", extra);
        else pass_cnt++;
        launch(K4, 32'd7, 32'd2);
        wait_valid(K4, 40, cyc, got);
        qd = exp_diff_q.pop_front(); qb = exp_borrow_q.pop_front();
        total_cnt++;
        if (!got || diff_v[K4] !== 32'd5 || diff_v[K4] !== qd || borrow_v[K4] !== qb)
            $display("FAIL async_next_op: got valid=%b diff=%h borrow=%b expected 1 00000005 0",
                     got, diff_v[K4], borrow_v[K4]);
        else pass_cnt++;
        $display("async_reset: next op Diff=%h", diff_v[K4]);
    endtask

    task automatic test_back_to_back(input int k, input int count);
        int n, issued, recvd, cyc, prev, budget, bad;
        logic [31:0] a, b, qd; logic qb;
        n = 32 / digit_of(k);
        issued = 0; recvd = 0; cyc = 0; prev = -1; bad = 0;
        budget = (count + 2) * (n + 2) + 50;
        while (recvd < count && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (valid_v[k] === 1'b1) begin
                total_cnt++;
                if (exp_diff_q.size() == 0) begin
                    $display("FAIL b2b_unexpected[d=%0d]: got valid with diff=%h expected none", digit_of(k), diff_v[k]);
                end else begin
                    qd = exp_diff_q.pop_front(); qb = exp_borrow_q.pop_front();
                    if (diff_v[k] !== qd || borrow_v[k] !== qb) begin
                        $display("FAIL b2b_result[d=%0d #%0d]: got %h/%b expected %h/%b",
                                 digit_of(k), recvd, diff_v[k], borrow_v[k], qd, qb);
                        bad++;
                    end else pass_cnt++;
                end
                if (prev >= 0) begin
                    total_cnt++;
                    if (cyc - prev !== n + 2)
                        $display("FAIL b2b_spacing[d=%0d #%0d]: got %0d expected %0d", digit_of(k), recvd, cyc - prev, n + 2);
                    else pass_cnt++;
                end
                prev = cyc;
                recvd++;
            end
            if (ready_v[k] === 1'b1 && issued < count) begin
                case ($urandom_range(0, 7))
                    0: begin a = $urandom(); b = a; end
                    1: begin a = 32'h0; b = $urandom(); end
                    2: begin a = $urandom(); b = 32'h0; end
                    3: begin a = 32'hFFFF_FFFF; b = $urandom(); end
                    default: begin a = $urandom(); b = $urandom(); end
                endcase
                a_v[k] = a; b_v[k] = b; start_v[k] = 1'b1;
                exp_diff_q.push_back(a - b);
                exp_borrow_q.push_back(a < b);
                issued++;
            end else if (issued >= count) begin
                start_v[k] = 1'b0;
            end
        end
        start_v[k] = 1'b0;
        total_cnt++;
        if (recvd !== count) $display("FAIL b2b_timeout[d=%0d]: got %0d results expected %0d", digit_of(k), recvd, count);
        else pass_cnt++;
        exp_diff_q.delete(); exp_borrow_q.delete();
        $display("back_to_back: DIGIT=%0d ops=%0d results=%0d mismatched=%0d", digit_of(k), count, recvd, bad);
        repeat (n + 4) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_ignored_start();
        test_async_reset();
        test_back_to_back(1, 1000);
        test_back_to_back(0, 150);
        test_back_to_back(2, 300);
        test_back_to_back(3, 300);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
